// File: rtl/carregador_instrucoes_pkg.sv
// carregador_instrucoes_pkg
// Shared definitions for the instruction-memory boot loader: the loader FSM
// states, the number of bytes packed per word and the default sizing values.
// No ports (package only).
package carregador_instrucoes_pkg;

  // Loader states: waiting, collecting bytes, writing one word, load finished.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RECEBE  = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int BYTES_POR_PALAVRA = 4;
  localparam int NBYTE_W           = $clog2(BYTES_POR_PALAVRA);

  localparam int          MAX_PALAVRAS_PADRAO = 256;
  localparam logic [31:0] END_BASE_PADRAO     = 32'h0000_0000;

endpackage

// File: rtl/carregador_instrucoes_empacotador.sv
// empacotador_palavra
// Packs consecutive accepted bytes little-endian into a 32-bit word.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset, discards partial word
//   limpar         in   synchronous clear of byte counter and partial word
//   byte_en        in   a byte is accepted this cycle
//   byte_dado      in   the byte being accepted
//   palavra        out  partial word with the current byte already merged in
//   palavra_pronta out  this cycle's accepted byte completes the word
module empacotador_palavra
  import carregador_instrucoes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        limpar,
  input  logic        byte_en,
  input  logic [7:0]  byte_dado,
  output logic [31:0] palavra,
  output logic        palavra_pronta
);

  logic [NBYTE_W-1:0] nbyte;
  logic [31:0]        parcial;

  // The merged word is offered combinationally so the top can register the
  // complete word on the same edge that accepts the last byte.
  always_comb begin
    palavra                 = parcial;
    palavra[8*nbyte +: 8]   = byte_dado;
    palavra_pronta          = byte_en && (nbyte == NBYTE_W'(BYTES_POR_PALAVRA - 1));
  end

  // Counter wraps to zero after the last byte, ready for the next word.
  always_ff @(posedge clk) begin
    if (reset || limpar) begin
      nbyte   <= '0;
      parcial <= '0;
    end else if (byte_en) begin
      parcial <= palavra;
      nbyte   <= nbyte + 1'b1;
    end
  end

endmodule

// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes
// Boot-time loader: receives a byte stream, packs bytes into words, writes
// them to consecutive instruction-memory addresses and then releases the CPU.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   inicio, num_palavras       start pulse and number of words to load
//   abortar                    cancel a load in progress
//   byte_valid/byte_dado/byte_ready   byte stream handshake
//   mem_we/mem_endereco/mem_dado      instruction memory write port
//   ocupado, concluido, erro   status
//   cpu_reset                  holds the CPU in reset until loading completes
module carregador_instrucoes
  import carregador_instrucoes_pkg::*;
#(
  parameter int          MAX_PALAVRAS = MAX_PALAVRAS_PADRAO,
  parameter logic [31:0] END_BASE     = END_BASE_PADRAO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inicio,
  input  logic [8:0]  num_palavras,
  input  logic        abortar,
  input  logic        byte_valid,
  input  logic [7:0]  byte_dado,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_dado,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro,
  output logic        cpu_reset
);

  localparam int IW = $clog2(MAX_PALAVRAS);

  estado_t       estado;
  logic [IW-1:0] indice;
  logic [8:0]    num_reg;
  logic          mem_we_q;
  logic          byte_en;
  logic          limpar;
  logic          num_valido;
  logic          ultima;
  logic [31:0]   palavra;
  logic          palavra_pronta;

  // Abort takes precedence over a byte arriving in the same cycle.
  assign byte_en    = byte_valid && byte_ready && !abortar;
  assign limpar     = (abortar && ocupado) || (inicio && !ocupado);
  assign num_valido = (num_palavras != 9'd0) && (num_palavras <= 9'(MAX_PALAVRAS));
  assign ultima     = (num_reg == (9'(indice) + 9'd1));

  // The write strobe is registered, but an abort in the write cycle must
  // still cancel it, so the registered strobe is gated by abortar.
  assign mem_we = mem_we_q && !abortar;

  empacotador_palavra u_empacotador (
    .clk            (clk),
    .reset          (reset),
    .limpar         (limpar),
    .byte_en        (byte_en),
    .byte_dado      (byte_dado),
    .palavra        (palavra),
    .palavra_pronta (palavra_pronta)
  );

  // Loader FSM with all status and memory-port outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= OCIOSO;
      indice       <= '0;
      num_reg      <= '0;
      byte_ready   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      ocupado      <= 1'b0;
      concluido    <= 1'b0;
      erro         <= 1'b0;
      cpu_reset    <= 1'b1;
    end else begin
      mem_we_q <= 1'b0;
      case (estado)
        OCIOSO, FIM: begin
          if (inicio) begin
            erro      <= 1'b0;
            concluido <= 1'b0;
            cpu_reset <= 1'b1;
            if (num_valido) begin
              estado     <= RECEBE;
              indice     <= '0;
              num_reg    <= num_palavras;
              byte_ready <= 1'b1;
              ocupado    <= 1'b1;
            end else begin
              erro   <= 1'b1;
              estado <= OCIOSO;
            end
          end
        end
        RECEBE: begin
          if (abortar) begin
            estado     <= OCIOSO;
            erro       <= 1'b1;
            ocupado    <= 1'b0;
            byte_ready <= 1'b0;
            concluido  <= 1'b0;
            cpu_reset  <= 1'b1;
          end else if (palavra_pronta) begin
            estado       <= ESCREVE;
            byte_ready   <= 1'b0;
            mem_we_q     <= 1'b1;
            mem_endereco <= END_BASE + 32'({indice, 2'b00});
            mem_dado     <= palavra;
          end
        end
        ESCREVE: begin
          if (abortar) begin
            estado     <= OCIOSO;
            erro       <= 1'b1;
            ocupado    <= 1'b0;
            byte_ready <= 1'b0;
            concluido  <= 1'b0;
            cpu_reset  <= 1'b1;
          end else if (ultima) begin
            estado    <= FIM;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            estado     <= RECEBE;
            indice     <= indice + 1'b1;
            byte_ready <= 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb_carregador_instrucoes
// Self-checking bench for the boot loader. Expected memory writes are derived
// from the list of bytes sent: word i goes to address 4*i and holds bytes
// 4i..4i+3 little-endian.
module tb_carregador_instrucoes;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic [8:0]  num_palavras;
  logic        abortar;
  logic        byte_valid;
  logic [7:0]  byte_dado;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dado;
  logic        ocupado;
  logic        concluido;
  logic        erro;
  logic        cpu_reset;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        obs[$];
  logic [7:0] stim_bytes[$];
  int         checks   = 0;
  int         failures = 0;

  carregador_instrucoes dut (
    .clk          (clk),
    .reset        (reset),
    .inicio       (inicio),
    .num_palavras (num_palavras),
    .abortar      (abortar),
    .byte_valid   (byte_valid),
    .byte_dado    (byte_dado),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .ocupado      (ocupado),
    .concluido    (concluido),
    .erro         (erro),
    .cpu_reset    (cpu_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write in the middle of the cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) obs.push_back('{a: mem_endereco, d: mem_dado});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input int num);
    inicio       = 1'b1;
    num_palavras = 9'(num);
    tick();
    inicio = 1'b0;
  endtask

  // Random idle gap, then hold the byte until the loader takes it.
  task automatic sendByte(input logic [7:0] b, input int gap_max);
    int gap;
    int budget;
    bit was_ready;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_dado  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_dado  = b;
    budget     = 0;
    forever begin
      was_ready = byte_ready;
      tick();
      if (was_ready) break;
      budget++;
      if (budget > 20) begin
        checkOutput("byte_timeout", 32'd1, 32'd0);
        break;
      end
    end
    byte_valid = 1'b0;
    byte_dado  = 8'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (concluido !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done", 32'(concluido), 32'd1);
  endtask

  // Reference: word i = stim_bytes[4i..4i+3] little-endian at address 4*i.
  task automatic compareWrites(input int num);
    logic [31:0] w;
    checkOutput("write_count", 32'(obs.size()), 32'(num));
    for (int i = 0; i < num && i < obs.size(); i++) begin
      w = 32'(stim_bytes[4*i]) + (32'(stim_bytes[4*i+1]) << 8)
        + (32'(stim_bytes[4*i+2]) << 16) + (32'(stim_bytes[4*i+3]) << 24);
      checkOutput($sformatf("addr%0d", i), obs[i].a, 32'(4 * i));
      checkOutput($sformatf("data%0d", i), obs[i].d, w);
    end
  endtask

  task automatic applyStimulus(input int num, input int gap_max);
    obs.delete();
    startLoad(num);
    for (int i = 0; i < 4 * num; i++) sendByte(stim_bytes[i], gap_max);
    waitDone(20);
    compareWrites(num);
    checkOutput("cpu_reset_fim", 32'(cpu_reset), 32'd0);
    checkOutput("erro_fim", 32'(erro), 32'd0);
    checkOutput("ocupado_fim", 32'(ocupado), 32'd0);
  endtask

  task automatic fillRandom(input int nbytes);
    stim_bytes.delete();
    for (int i = 0; i < nbytes; i++) stim_bytes.push_back(8'($urandom));
  endtask

  initial begin
    reset        = 1'b1;
    inicio       = 1'b0;
    num_palavras = '0;
    abortar      = 1'b0;
    byte_valid   = 1'b0;
    byte_dado    = '0;

    // Test 1: reset values.
    tick();
    tick();
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_ocupado", 32'(ocupado), 32'd0);
    checkOutput("rst_concluido", 32'(concluido), 32'd0);
    checkOutput("rst_erro", 32'(erro), 32'd0);
    checkOutput("rst_endereco", mem_endereco, 32'd0);
    checkOutput("rst_dado", mem_dado, 32'd0);
    reset = 1'b0;
    tick();

    // Test 2: one word, write latency and release of the CPU.
    $display("[TB] single word load");
    stim_bytes = '{8'h13, 8'h00, 8'h00, 8'h00};
    obs.delete();
    startLoad(1);
    checkOutput("t2_ocupado", 32'(ocupado), 32'd1);
    for (int i = 0; i < 4; i++) sendByte(stim_bytes[i], 0);
    checkOutput("t2_mem_we", 32'(mem_we), 32'd1);
    checkOutput("t2_ready_drop", 32'(byte_ready), 32'd0);
    checkOutput("t2_endereco", mem_endereco, 32'h0);
    checkOutput("t2_dado", mem_dado, 32'h0000_0013);
    tick();
    checkOutput("t2_concluido", 32'(concluido), 32'd1);
    checkOutput("t2_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("t2_mem_we_off", 32'(mem_we), 32'd0);
    compareWrites(1);

    // Test 3: three words with random valid gaps.
    $display("[TB] three word load with gaps");
    fillRandom(12);
    stim_bytes[0] = 8'h8C;
    stim_bytes[1] = 8'h08;
    stim_bytes[2] = 8'h00;
    stim_bytes[3] = 8'h20;
    applyStimulus(3, 3);
    if (obs.size() > 0) checkOutput("t3_word0", obs[0].d, 32'h2000_088C);

    // Randomized loads of various lengths.
    for (int r = 0; r < 5; r++) begin
      int n;
      n = int'($urandom_range(6, 1));
      fillRandom(4 * n);
      applyStimulus(n, 2);
    end

    // Test 4: invalid word counts.
    $display("[TB] invalid word counts");
    obs.delete();
    startLoad(0);
    checkOutput("t4_erro0", 32'(erro), 32'd1);
    checkOutput("t4_ocupado0", 32'(ocupado), 32'd0);
    checkOutput("t4_concluido0", 32'(concluido), 32'd0);
    checkOutput("t4_cpu_reset0", 32'(cpu_reset), 32'd1);
    checkOutput("t4_ready0", 32'(byte_ready), 32'd0);
    tick();
    startLoad(257);
    checkOutput("t4_erro257", 32'(erro), 32'd1);
    checkOutput("t4_ocupado257", 32'(ocupado), 32'd0);
    byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    byte_valid = 1'b0;
    checkOutput("t4_no_writes", 32'(obs.size()), 32'd0);
    fillRandom(4);
    obs.delete();
    startLoad(1);
    checkOutput("t4_erro_clear", 32'(erro), 32'd0);
    for (int i = 0; i < 4; i++) sendByte(stim_bytes[i], 1);
    waitDone(20);
    compareWrites(1);

    // Test 5: abort in the middle of word 1.
    $display("[TB] abort while receiving");
    fillRandom(12);
    obs.delete();
    startLoad(3);
    for (int i = 0; i < 6; i++) sendByte(stim_bytes[i], 1);
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    byte_valid = 1'b0;
    compareWrites(1);
    checkOutput("t5_erro", 32'(erro), 32'd1);
    checkOutput("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("t5_concluido", 32'(concluido), 32'd0);
    checkOutput("t5_ocupado", 32'(ocupado), 32'd0);

    // Abort coincident with the write cycle suppresses the write.
    $display("[TB] abort during write");
    fillRandom(8);
    obs.delete();
    startLoad(2);
    for (int i = 0; i < 4; i++) sendByte(stim_bytes[i], 0);
    abortar = 1'b1;
    #3;
    checkOutput("t5w_mem_we", 32'(mem_we), 32'd0);
    tick();
    abortar = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t5w_writes", 32'(obs.size()), 32'd0);
    checkOutput("t5w_erro", 32'(erro), 32'd1);

    // Test 6: reset mid-word discards the stale bytes.
    $display("[TB] reset mid load");
    obs.delete();
    startLoad(2);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("t6_ocupado", 32'(ocupado), 32'd0);
    stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    obs.delete();
    startLoad(1);
    for (int i = 0; i < 4; i++) sendByte(stim_bytes[i], 0);
    waitDone(20);
    compareWrites(1);

    // Largest legal load, back-to-back bytes.
    $display("[TB] maximum length load");
    fillRandom(4 * 256);
    applyStimulus(256, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
